// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  // Widest data word a writeback request can carry; narrower DATA_WIDTH values are zero-extended.
  localparam int WB_DATA_W  = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0]  wdata;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Per-source writeback FIFO: registered head plus per-entry valid/address taps
// so the top can report which registers still have writes in flight.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  wb_req_t               wr_req,
  output logic                  full,
  output logic                  empty,
  output wb_req_t               head,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [REG_ADDR_W-1:0] entry_addr [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t          mem_reg [DEPTH];
  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic             do_push, do_pop;

  // Occupancy is contiguous, so the valid bits double as the full/empty state.
  assign full    = &valid_reg;
  assign empty   = ~|valid_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    valid_next = valid_reg;
    if (do_push) valid_next[wr_ptr_reg] = 1'b1;
    if (do_pop)  valid_next[rd_ptr_reg] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      valid_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem_reg[wr_ptr_reg] <= wr_req;
  end

  assign head        = mem_reg[rd_ptr_reg];
  assign entry_valid = valid_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
    assign entry_addr[gi] = mem_reg[gi].waddr;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Collects writebacks from NR_SRC units into per-source FIFOs and issues up to
// NR_WRITE_PORTS conflict-free register writes per cycle in round-robin order.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int NR_SRC         = 4,
  parameter int NR_WRITE_PORTS = 2,
  parameter int FIFO_DEPTH     = 2,
  parameter bit ZERO_REG_ZERO  = 1'b0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [NR_SRC-1:0]                    src_valid_i,
  output logic [NR_SRC-1:0]                    src_ready_o,
  input  logic [NR_SRC*REG_ADDR_W-1:0]         src_waddr_i,
  input  logic [NR_SRC*DATA_WIDTH-1:0]         src_wdata_i,
  output logic [NR_WRITE_PORTS*REG_ADDR_W-1:0] waddr_o,
  output logic [NR_WRITE_PORTS*DATA_WIDTH-1:0] wdata_o,
  output logic [NR_WRITE_PORTS-1:0]            we_o,
  output logic [NUM_REGS-1:0]                  pending_o,
  output logic                                 busy_o
);

  localparam int SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

  wb_req_t               src_req [NR_SRC];
  wb_req_t               head    [NR_SRC];
  logic [NR_SRC-1:0]     full, empty, push, pop;
  logic [FIFO_DEPTH-1:0] ent_valid [NR_SRC];
  logic [REG_ADDR_W-1:0] ent_addr  [NR_SRC][FIFO_DEPTH];

  logic [SRC_W-1:0]          rr_ptr_reg, rr_ptr_next;
  logic [NR_WRITE_PORTS-1:0] we_reg, we_next;
  logic [REG_ADDR_W-1:0]     waddr_reg [NR_WRITE_PORTS];
  logic [REG_ADDR_W-1:0]     waddr_next [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0]     wdata_reg [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0]     wdata_next [NR_WRITE_PORTS];

  logic [SRC_W-1:0] arb_src;
  logic             arb_hit;
  int               arb_cnt;

  for (genvar gi = 0; gi < NR_SRC; gi++) begin : g_src
    logic drop;

    assign src_req[gi].waddr = src_waddr_i[gi*REG_ADDR_W +: REG_ADDR_W];
    assign src_req[gi].wdata = WB_DATA_W'(src_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH]);
    assign src_ready_o[gi]   = !full[gi] && !flush_i && !rst_i;
    // x0 writes are acknowledged to the source but never buffered.
    assign drop              = ZERO_REG_ZERO && (src_req[gi].waddr == '0);
    assign push[gi]          = src_valid_i[gi] && src_ready_o[gi] && !drop;

    wb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush       (flush_i),
      .push        (push[gi]),
      .pop         (pop[gi]),
      .wr_req      (src_req[gi]),
      .full        (full[gi]),
      .empty       (empty[gi]),
      .head        (head[gi]),
      .entry_valid (ent_valid[gi]),
      .entry_addr  (ent_addr[gi])
    );
  end

  // Scan heads from rr_ptr; a head whose address is already granted is skipped
  // so the remaining sources can still use the free ports.
  always_comb begin
    pop         = '0;
    we_next     = '0;
    waddr_next  = waddr_reg;
    wdata_next  = wdata_reg;
    rr_ptr_next = rr_ptr_reg;
    arb_src     = '0;
    arb_hit     = 1'b0;
    arb_cnt     = 0;
    for (int i = 0; i < NR_SRC; i++) begin
      arb_src = SRC_W'((int'(rr_ptr_reg) + i) % NR_SRC);
      arb_hit = 1'b0;
      for (int k = 0; k < NR_WRITE_PORTS; k++) begin
        if (we_next[k] && (waddr_next[k] == head[arb_src].waddr)) arb_hit = 1'b1;
      end
      if (!flush_i && !empty[arb_src] && !arb_hit && (arb_cnt < NR_WRITE_PORTS)) begin
        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
          if (k == arb_cnt) begin
            we_next[k]    = 1'b1;
            waddr_next[k] = head[arb_src].waddr;
            wdata_next[k] = head[arb_src].wdata[DATA_WIDTH-1:0];
          end
        end
        pop[arb_src] = 1'b1;
        rr_ptr_next  = (arb_src == SRC_W'(NR_SRC - 1)) ? '0 : arb_src + SRC_W'(1);
        arb_cnt      = arb_cnt + 1;
      end
    end
    if (flush_i) rr_ptr_next = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_reg <= '0;
      we_reg     <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      we_reg     <= we_next;
    end
  end

  for (genvar gi = 0; gi < NR_WRITE_PORTS; gi++) begin : g_port
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        waddr_reg[gi] <= '0;
        wdata_reg[gi] <= '0;
      end else begin
        waddr_reg[gi] <= waddr_next[gi];
        wdata_reg[gi] <= wdata_next[gi];
      end
    end

    assign waddr_o[gi*REG_ADDR_W +: REG_ADDR_W] = waddr_reg[gi];
    assign wdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = wdata_reg[gi];
  end

  assign we_o = we_reg;

  always_comb begin
    pending_o = '0;
    for (int s = 0; s < NR_SRC; s++) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        if (ent_valid[s][e]) pending_o[ent_addr[s][e]] = 1'b1;
      end
    end
    for (int k = 0; k < NR_WRITE_PORTS; k++) begin
      if (we_reg[k]) pending_o[waddr_reg[k]] = 1'b1;
    end
  end

  assign busy_o = (~&empty) | (|we_reg);

endmodule
